// File: rtl/seq_lock_detector.sv
// Sequential code-lock detector.
// Watches debounced key levels for rising edges, compares each press against
// a code captured at the start of an attempt, and reports unlock, fail and
// lockout through registered Moore outputs.
module seq_lock_detector #(
  parameter int SEQ_LEN     = 4,
  parameter int NUM_KEYS    = 2,
  parameter int TIMEOUT_CYC = 1000,
  parameter int MAX_FAIL    = 3,
  parameter int LOCKOUT_CYC = 5000,
  localparam int SYM_W      = ($clog2(NUM_KEYS) > 1) ? $clog2(NUM_KEYS) : 1,
  localparam int PROG_W     = $clog2(SEQ_LEN + 1)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_KEYS-1:0]      key,
  input  logic [SEQ_LEN*SYM_W-1:0] code,
  output logic                     unlock,
  output logic                     fail,
  output logic                     locked_out,
  output logic [PROG_W-1:0]        progress,
  output logic                     busy
);

  localparam int TMO_W  = $clog2(TIMEOUT_CYC + 1);
  localparam int LCK_W  = $clog2(LOCKOUT_CYC + 1);
  localparam int FCNT_W = $clog2(MAX_FAIL + 1);

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_ENTRY   = 3'd1;
  localparam logic [2:0] ST_MATCH   = 3'd2;
  localparam logic [2:0] ST_FAIL    = 3'd3;
  localparam logic [2:0] ST_LOCKOUT = 3'd4;

  localparam logic [NUM_KEYS-1:0] KEY_ONE   = NUM_KEYS'(1);
  localparam logic [PROG_W-1:0]   PROG_ONE  = PROG_W'(1);
  localparam logic [PROG_W-1:0]   PROG_LAST = PROG_W'(SEQ_LEN - 1);
  localparam logic [TMO_W-1:0]    TMO_ONE   = TMO_W'(1);
  localparam logic [TMO_W-1:0]    TMO_LAST  = TMO_W'(TIMEOUT_CYC - 1);
  localparam logic [LCK_W-1:0]    LCK_ONE   = LCK_W'(1);
  localparam logic [LCK_W-1:0]    LCK_LAST  = LCK_W'(LOCKOUT_CYC - 1);
  localparam logic [FCNT_W-1:0]   FCNT_ONE  = FCNT_W'(1);
  localparam logic [FCNT_W-1:0]   FCNT_MAX  = FCNT_W'(MAX_FAIL);

  // Index of the highest set bit; only meaningful for a one-hot vector.
  function automatic logic [SYM_W-1:0] f_encode(input logic [NUM_KEYS-1:0] v);
    logic [SYM_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < NUM_KEYS; i++) begin
      if (v[i]) begin
        idx = SYM_W'(i);
      end else begin
        idx = idx;
      end
    end
    return idx;
  endfunction

  // Symbol at position pos of a packed code word.
  function automatic logic [SYM_W-1:0] f_code_sym(input logic [SEQ_LEN*SYM_W-1:0] c,
                                                  input logic [PROG_W-1:0] pos);
    logic [SYM_W-1:0] sym;
    sym = '0;
    for (int i = 0; i < SEQ_LEN; i++) begin
      if (pos == PROG_W'(i)) begin
        sym = c[i*SYM_W +: SYM_W];
      end else begin
        sym = sym;
      end
    end
    return sym;
  endfunction

  logic [NUM_KEYS-1:0]      r_key_q;
  logic [2:0]               r_state;
  logic [SEQ_LEN*SYM_W-1:0] r_code;
  logic [PROG_W-1:0]        r_prog;
  logic [FCNT_W-1:0]        r_fail_cnt;
  logic [TMO_W-1:0]         r_tmo_cnt;
  logic [LCK_W-1:0]         r_lock_cnt;
  logic                     r_unlock;
  logic                     r_fail;
  logic                     r_locked_out;
  logic                     r_busy;

  logic [NUM_KEYS-1:0]      w_rise;
  logic                     w_press;
  logic                     w_single;
  logic [SYM_W-1:0]         w_sym;
  logic [SYM_W-1:0]         w_expect;
  logic                     w_sym_ok;
  logic [2:0]               w_state_nxt;
  logic [SEQ_LEN*SYM_W-1:0] w_code_nxt;
  logic [PROG_W-1:0]        w_prog_nxt;
  logic [FCNT_W-1:0]        w_fail_cnt_nxt;
  logic [FCNT_W-1:0]        w_fail_inc;
  logic [TMO_W-1:0]         w_tmo_nxt;
  logic [LCK_W-1:0]         w_lock_nxt;

  assign w_rise     = key & ~r_key_q;
  assign w_press    = (w_rise != '0);
  assign w_single   = w_press && ((w_rise & (w_rise - KEY_ONE)) == '0);
  assign w_sym      = f_encode(w_rise);
  assign w_fail_inc = (r_fail_cnt == FCNT_MAX) ? r_fail_cnt : (r_fail_cnt + FCNT_ONE);

  // Expected symbol: live code for the first press, captured code afterwards.
  always_comb begin
    w_expect = '0;
    if (r_state == ST_IDLE) begin
      w_expect = code[SYM_W-1:0];
    end else begin
      w_expect = f_code_sym(r_code, r_prog);
    end
    w_sym_ok = w_single && (w_sym == w_expect);
  end

  // Next-state and counter update logic.
  always_comb begin
    w_state_nxt    = r_state;
    w_code_nxt     = r_code;
    w_prog_nxt     = r_prog;
    w_fail_cnt_nxt = r_fail_cnt;
    w_tmo_nxt      = r_tmo_cnt;
    w_lock_nxt     = r_lock_cnt;
    case (r_state)
      ST_IDLE: begin
        if (w_press) begin
          w_code_nxt = code;
          w_tmo_nxt  = '0;
          if (w_sym_ok) begin
            w_state_nxt = ST_ENTRY;
            w_prog_nxt  = PROG_ONE;
          end else begin
            w_state_nxt    = ST_FAIL;
            w_fail_cnt_nxt = w_fail_inc;
          end
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_ENTRY: begin
        if (w_press) begin
          w_tmo_nxt = '0;
          if (w_sym_ok) begin
            w_prog_nxt = r_prog + PROG_ONE;
            if (r_prog == PROG_LAST) begin
              w_state_nxt = ST_MATCH;
            end else begin
              w_state_nxt = ST_ENTRY;
            end
          end else begin
            w_state_nxt    = ST_FAIL;
            w_fail_cnt_nxt = w_fail_inc;
          end
        end else if (r_tmo_cnt == TMO_LAST) begin
          // Abandoned attempt: silent return, fail count untouched.
          w_state_nxt = ST_IDLE;
          w_prog_nxt  = '0;
          w_tmo_nxt   = '0;
        end else begin
          w_tmo_nxt = r_tmo_cnt + TMO_ONE;
        end
      end
      ST_MATCH: begin
        w_state_nxt    = ST_IDLE;
        w_prog_nxt     = '0;
        w_fail_cnt_nxt = '0;
      end
      ST_FAIL: begin
        w_prog_nxt = '0;
        w_lock_nxt = '0;
        if (r_fail_cnt == FCNT_MAX) begin
          w_state_nxt = ST_LOCKOUT;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_LOCKOUT: begin
        if (r_lock_cnt == LCK_LAST) begin
          w_state_nxt    = ST_IDLE;
          w_lock_nxt     = '0;
          w_fail_cnt_nxt = '0;
        end else begin
          w_lock_nxt = r_lock_cnt + LCK_ONE;
        end
      end
      default: begin
        w_state_nxt    = ST_IDLE;
        w_prog_nxt     = '0;
        w_fail_cnt_nxt = '0;
        w_tmo_nxt      = '0;
        w_lock_nxt     = '0;
      end
    endcase
  end

  // State, counters, captured code and key history.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_key_q    <= '0;
      r_state    <= ST_IDLE;
      r_code     <= '0;
      r_prog     <= '0;
      r_fail_cnt <= '0;
      r_tmo_cnt  <= '0;
      r_lock_cnt <= '0;
    end else begin
      r_key_q    <= key;
      r_state    <= w_state_nxt;
      r_code     <= w_code_nxt;
      r_prog     <= w_prog_nxt;
      r_fail_cnt <= w_fail_cnt_nxt;
      r_tmo_cnt  <= w_tmo_nxt;
      r_lock_cnt <= w_lock_nxt;
    end
  end

  // Moore outputs registered alongside the state they decode.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_unlock     <= 1'b0;
      r_fail       <= 1'b0;
      r_locked_out <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_unlock     <= (w_state_nxt == ST_MATCH);
      r_fail       <= (w_state_nxt == ST_FAIL);
      r_locked_out <= (w_state_nxt == ST_LOCKOUT);
      r_busy       <= (w_state_nxt == ST_ENTRY);
    end
  end

  assign unlock     = r_unlock;
  assign fail       = r_fail;
  assign locked_out = r_locked_out;
  assign busy       = r_busy;
  assign progress   = r_prog;

endmodule

// File: tb/tb_seq_lock_detector.sv
// Self-checking bench for seq_lock_detector with default parameters.
module tb_seq_lock_detector;

  localparam int SEQ_LEN     = 4;
  localparam int NUM_KEYS    = 2;
  localparam int TIMEOUT_CYC = 1000;
  localparam int MAX_FAIL    = 3;
  localparam int LOCKOUT_CYC = 5000;

  logic       clk;
  logic       reset;
  logic [1:0] key;
  logic [3:0] code;
  logic       unlock;
  logic       fail;
  logic       locked_out;
  logic [2:0] progress;
  logic       busy;

  seq_lock_detector #(
    .SEQ_LEN(SEQ_LEN), .NUM_KEYS(NUM_KEYS), .TIMEOUT_CYC(TIMEOUT_CYC),
    .MAX_FAIL(MAX_FAIL), .LOCKOUT_CYC(LOCKOUT_CYC)
  ) dut (
    .clk(clk), .reset(reset), .key(key), .code(code),
    .unlock(unlock), .fail(fail), .locked_out(locked_out),
    .progress(progress), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int unlock_seen = 0;
  int lock_seen   = 0;

  // Reference model: attempt position, pending one-cycle event, lockout time left.
  logic [1:0] m_prev;
  int m_pos, m_pend, m_lock, m_fails, m_idle;
  int m_cap[SEQ_LEN];

  task automatic model_reset();
    m_prev = 2'b00; m_pos = 0; m_pend = 0; m_lock = 0; m_fails = 0; m_idle = 0;
  endtask

  task automatic model_step(input logic [1:0] k, input logic [3:0] c);
    logic [1:0] rise;
    int nr, idx;
    rise = k & ~m_prev;
    m_prev = k;
    nr = 0; idx = 0;
    for (int i = 0; i < NUM_KEYS; i++) if (rise[i]) begin nr++; idx = i; end
    if (m_pend == 1) begin
      m_pend = 0; m_pos = 0; m_fails = 0;
    end else if (m_pend == 2) begin
      m_pend = 0; m_pos = 0;
      if (m_fails == MAX_FAIL) m_lock = LOCKOUT_CYC;
    end else if (m_lock > 0) begin
      m_lock--;
      if (m_lock == 0) m_fails = 0;
    end else if (nr > 0) begin
      if (m_pos == 0) for (int i = 0; i < SEQ_LEN; i++) m_cap[i] = int'(c[i]);
      m_idle = 0;
      if (nr == 1 && idx == m_cap[m_pos]) begin
        m_pos++;
        if (m_pos == SEQ_LEN) m_pend = 1;
      end else begin
        m_pend = 2;
        if (m_fails < MAX_FAIL) m_fails++;
      end
    end else if (m_pos > 0) begin
      m_idle++;
      if (m_idle == TIMEOUT_CYC) begin m_pos = 0; m_idle = 0; end
    end
  endtask

  function automatic logic [6:0] model_out();
    logic [6:0] v;
    v = {(m_pend == 1), (m_pend == 2), (m_lock > 0),
         (m_pos > 0 && m_pend == 0 && m_lock == 0), 3'(m_pos)};
    return v;
  endfunction

  function automatic logic [6:0] dut_out();
    return {unlock, fail, locked_out, busy, progress};
  endfunction

  task automatic chk(input string name, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  // One clock: drive key, step model at the edge, compare on the falling edge.
  task automatic step(input logic [1:0] k);
    key = k;
    @(posedge clk);
    model_step(k, code);
    @(negedge clk);
    chk("model", int'(dut_out()), int'(model_out()));
    if (unlock) unlock_seen++;
    if (locked_out) lock_seen++;
  endtask

  task automatic do_reset(input logic [1:0] k);
    reset = 1'b0;
    key = k;
    #2;
    chk("rst_outputs", int'(dut_out()), 0);
    model_reset();
    @(negedge clk);
    reset = 1'b1;
  endtask

  // Presses the four symbols of c, releasing between presses.
  task automatic enter_code(input logic [3:0] c);
    for (int i = 0; i < SEQ_LEN; i++) begin
      step(c[i] ? 2'b10 : 2'b01);
      step(2'b00);
    end
  endtask

  typedef struct {
    logic [1:0] k;
    logic [6:0] exp;  // {unlock, fail, locked_out, busy, progress}
  } vec_t;

  vec_t tbl[16];

  initial begin
    tbl[0]  = '{2'b01, 7'b0001001};
    tbl[1]  = '{2'b00, 7'b0001001};
    tbl[2]  = '{2'b01, 7'b0001010};
    tbl[3]  = '{2'b00, 7'b0001010};
    tbl[4]  = '{2'b10, 7'b0001011};
    tbl[5]  = '{2'b00, 7'b0001011};
    tbl[6]  = '{2'b10, 7'b1000100};
    tbl[7]  = '{2'b00, 7'b0000000};
    tbl[8]  = '{2'b01, 7'b0001001};
    tbl[9]  = '{2'b10, 7'b0100001};
    tbl[10] = '{2'b00, 7'b0000000};
    tbl[11] = '{2'b11, 7'b0100000};
    tbl[12] = '{2'b00, 7'b0000000};
    tbl[13] = '{2'b01, 7'b0001001};
    tbl[14] = '{2'b01, 7'b0001001};
    tbl[15] = '{2'b01, 7'b0001001};

    reset = 1'b0;
    key   = 2'b00;
    code  = 4'b1100;
    model_reset();
    #3;
    chk("reset_state", int'(dut_out()), 0);
    @(negedge clk);
    reset = 1'b1;

    // Table: correct code, wrong symbol, simultaneous keys, held key.
    for (int i = 0; i < 16; i++) begin
      step(tbl[i].k);
      chk($sformatf("tbl%0d", i), int'(dut_out()), int'(tbl[i].exp));
    end

    // Held key keeps producing a single press.
    for (int i = 0; i < 47; i++) step(2'b01);
    chk("held_progress", int'(progress), 1);

    // Second press then timeout.
    step(2'b00);
    step(2'b01);
    chk("before_idle_prog", int'(progress), 2);
    for (int i = 0; i < TIMEOUT_CYC - 1; i++) step(2'b00);
    chk("tmo_busy_still", int'(busy), 1);
    step(2'b00);
    chk("tmo_busy", int'(busy), 0);
    chk("tmo_prog", int'(progress), 0);
    chk("tmo_nofail", int'(fail), 0);

    unlock_seen = 0;
    enter_code(4'b1100);
    chk("unlock_after_tmo", unlock_seen, 1);

    // Three wrong attempts, then lockout with a correct code entered inside it.
    unlock_seen = 0;
    lock_seen   = 0;
    for (int i = 0; i < MAX_FAIL; i++) begin
      step(2'b10);
      chk("wrong_fail", int'(fail), 1);
      step(2'b00);
    end
    chk("lock_start", int'(locked_out), 1);
    enter_code(4'b1100);
    for (int n = 0; n < LOCKOUT_CYC + 1000 && locked_out; n++) step(2'b00);
    chk("lock_len", lock_seen, LOCKOUT_CYC);
    chk("lock_no_unlock", unlock_seen, 0);
    enter_code(4'b1100);
    chk("unlock_after_lock", unlock_seen, 1);

    // Code changed during entry is ignored.
    unlock_seen = 0;
    step(2'b01); step(2'b00);
    code = 4'b0011;
    step(2'b01); step(2'b00);
    step(2'b10); step(2'b00);
    step(2'b10); step(2'b00);
    chk("code_change_unlock", unlock_seen, 1);
    code = 4'b1100;

    // Reset at progress 3, then the remaining symbol fails.
    step(2'b01); step(2'b00);
    step(2'b01); step(2'b00);
    step(2'b10); step(2'b00);
    chk("prog3", int'(progress), 3);
    do_reset(2'b00);
    step(2'b10);
    chk("post_rst_fail", int'(fail), 1);
    chk("post_rst_nounlock", int'(unlock), 0);
    step(2'b00);

    // Key already high at reset release is a press.
    do_reset(2'b01);
    step(2'b01);
    chk("press_at_release", int'(progress), 1);
    step(2'b00);

    // Random stimulus against the model.
    for (int n = 0; n < 20000; n++) begin
      if ($urandom_range(99) < 2) code = 4'($urandom);
      if ($urandom_range(4999) == 0) do_reset(2'($urandom));
      if ($urandom_range(99) < 60) step(2'b00);
      else step(2'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/seq_lock_detector.md
SEQ_LOCK_DETECTOR -- requirements
Module: seq_lock_detector

Interface
REQ-001 The block SHALL have parameter SEQ_LEN, default 4, meaning the number of symbols in the code (range 2..16).
REQ-002 The block SHALL have parameter NUM_KEYS, default 2, meaning the number of key inputs (range 2..16); SYM_W = max(1, clog2(NUM_KEYS)).
REQ-003 The block SHALL have parameter TIMEOUT_CYC, default 1000, meaning the maximum idle cycles allowed between presses during entry.
REQ-004 The block SHALL have parameter MAX_FAIL, default 3, meaning the number of consecutive failed attempts that triggers lockout.
REQ-005 The block SHALL have parameter LOCKOUT_CYC, default 5000, meaning the lockout duration in cycles.
REQ-006 The block SHALL have one clock; reset is asynchronous and active-low.
REQ-007 Port clk  input  1  system clock; all state updates on the rising edge.
REQ-008 Port reset  input  1  asynchronous, active-low reset.
REQ-009 Port key  input  NUM_KEYS  key levels, already synchronised and debounced to clk.
REQ-010 Port code  input  SEQ_LEN*SYM_W  expected code; symbol i in bits [i*SYM_W +: SYM_W]; symbol 0 is entered first.
REQ-011 Port unlock  output  1  one-cycle pulse on a correct full code.
REQ-012 Port fail  output  1  one-cycle pulse on a wrong symbol.
REQ-013 Port locked_out  output  1  high for the whole lockout period.
REQ-014 Port progress  output  clog2(SEQ_LEN+1)  count of correct symbols accepted in the current attempt.
REQ-015 Port busy  output  1  high while an attempt is in progress (state ENTRY).

Function
REQ-016 All outputs SHALL be registered Moore outputs, decoded from state and counters only.
REQ-017 A press event SHALL be a rising edge of any bit of key, detected against a registered copy key_q.
REQ-018 If exactly one bit rises, the press SHALL carry that bit's index as its symbol; if several bits rise together, the press SHALL be treated as a wrong symbol.
REQ-019 States SHALL be IDLE, ENTRY, MATCH, FAIL and LOCKOUT.
REQ-020 IDLE: on a press, code SHALL be captured into an internal register; a correct symbol 0 goes to ENTRY with progress=1; a wrong symbol goes to FAIL.
REQ-021 ENTRY: a correct symbol SHALL increment progress; if it was the final symbol, the next state SHALL be MATCH, otherwise ENTRY.
REQ-022 ENTRY: a wrong symbol SHALL go to FAIL.
REQ-023 Matching SHALL be non-overlapping: after FAIL, the wrong symbol is not reused as symbol 0.
REQ-024 ENTRY timeout: after TIMEOUT_CYC consecutive cycles with no press, the block SHALL return to IDLE with progress=0, no fail pulse, and the fail count unchanged.
REQ-025 Any press SHALL restart the timeout counter.
REQ-026 A change on code during ENTRY SHALL have no effect; the value captured at the first press is used.
REQ-027 MATCH SHALL last one cycle with unlock=1, clear the fail count and progress, then go to IDLE.
REQ-028 FAIL SHALL last one cycle with fail=1 and increment the fail count (saturating).
REQ-029 From FAIL, if the fail count equals MAX_FAIL the next state SHALL be LOCKOUT, otherwise IDLE; progress SHALL be cleared in both cases.
REQ-030 LOCKOUT SHALL hold locked_out=1 for exactly LOCKOUT_CYC cycles and ignore all presses, then go to IDLE with the fail count cleared.
REQ-031 Presses occurring while in MATCH, FAIL or LOCKOUT SHALL be discarded, while key_q still tracks key.
REQ-032 A key held high SHALL produce only one press event.
REQ-033 Latency: a press sampled at edge k SHALL be reflected in state, progress, unlock and fail after edge k.
REQ-034 Counters SHALL be sized to hold TIMEOUT_CYC and LOCKOUT_CYC without overflow.

Reset
REQ-035 With reset low, the block SHALL immediately enter IDLE with unlock=0, fail=0, locked_out=0, busy=0, progress=0, fail count=0, all counters=0 and key_q=0.
REQ-036 Reset asserted mid-attempt or during lockout SHALL abort it with no output pulse.
REQ-037 The first cycle after reset release SHALL detect a press if key is already high.

Verification (defaults, code = symbols 0,0,1,1)
REQ-038 Presses key[0],key[0],key[1],key[1] -> progress steps 1,2,3,4; unlock high for exactly one cycle after the 4th press edge; fail stays 0.
REQ-039 Presses 0,1 -> one fail pulse after the 2nd press; progress returns to 0; a following correct 0,0,1,1 -> unlock.
REQ-040 Three wrong attempts -> locked_out high for 5000 cycles; a correct code entered during lockout gives no unlock; the same code entered after lockout -> unlock.
REQ-041 Presses 0,0 then 1000 idle cycles -> busy falls and progress=0 with no fail pulse; then 0,0,1,1 -> unlock.
REQ-042 key=2'b11 rising together in IDLE -> fail pulse; key[0] held for 50 cycles -> a single press, progress=1.
REQ-043 Reset pulsed low at progress=3 -> outputs at reset values immediately; the remaining press 1 -> fail, not unlock.
